// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: blank pattern, hex decode
// table (active-low {g,f,e,d,c,b,a}) and the default digit count.
package seg7_pkg;

    localparam int unsigned N_DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element i holds the active-low pattern for hex value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segments_no
);

    always_comb begin
        segments_no = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed N-digit 7-segment scanner advancing one digit per tick_in rising edge.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = N_DIGITS_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  tick_in,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   anodes_n,
    output logic [6:0]            segments_n,
    output logic                  dp_n
);

    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITS - 1);

    logic            tick_q;
    logic            rise;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [3:0]          nibble_d;
    logic                dp_sel_d;
    logic [N_DIGITS-1:0] anodes_d;
    logic [6:0]          dec_seg;
    logic [6:0]          segments_d;

    assign rise = tick_in & ~tick_q;

    // Tracking tick_in through reset keeps a held-high tick from looking like an edge.
    always_ff @(posedge clk_in) begin
        tick_q <= tick_in;
    end

    always_comb begin
        idx_d    = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        nibble_d = '0;
        dp_sel_d = 1'b0;
        anodes_d = '1;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (idx_d == IdxW'(k)) begin
                nibble_d    = digits_in[4*k +: 4];
                dp_sel_d    = dp_in[k];
                anodes_d[k] = 1'b0;
            end
        end
    end

    seg7_decoder u_decoder (
        .nibble_i    (nibble_d),
        .segments_no (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: nibbles k..N_DIGITS-1 are all zero.
    logic [N_DIGITS-1:0] upper_zero;
    logic                blank_d;

    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            acc           = acc & (digits_in[4*k +: 4] == 4'h0);
            upper_zero[k] = acc;
        end
        blank_d = 1'b0;
        for (int k = 1; k < int'(N_DIGITS); k++) begin
            if (idx_d == IdxW'(k)) begin
                blank_d = upper_zero[k];
            end
        end
        segments_d = blank_d ? SEG_BLANK : dec_seg;
    end
`else
    always_comb begin
        segments_d = dec_seg;
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            idx_q      <= IdxLast;
            anodes_n   <= '1;
            segments_n <= SEG_BLANK;
            dp_n       <= 1'b1;
        end else if (rise) begin
            idx_q      <= idx_d;
            anodes_n   <= anodes_d;
            segments_n <= segments_d;
            dp_n       <= ~dp_sel_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (4 digits), sampling on negedge.
module tb_display_scanner;

    logic        clk_in;
    logic        reset;
    logic        tick_in;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  anodes_n;
    logic [6:0]  segments_n;
    logic        dp_n;

    int checks;
    int errors;

    display_scanner #(.N_DIGITS(4)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .anodes_n   (anodes_n),
        .segments_n (segments_n),
        .dp_n       (dp_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_out(input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp);
        checks++;
        assert (anodes_n === an) else begin
            errors++;
            $error("FAIL %s anodes_n: got %b expected %b", tag, anodes_n, an);
        end
        checks++;
        assert (segments_n === seg) else begin
            errors++;
            $error("FAIL %s segments_n: got %h expected %h", tag, segments_n, seg);
        end
        checks++;
        assert (dp_n === dp) else begin
            errors++;
            $error("FAIL %s dp_n: got %b expected %b", tag, dp_n, dp);
        end
    endtask

    // Drop tick for one cycle then raise it; returns at the negedge after the rise edge.
    task automatic step_rise();
        tick_in = 1'b0;
        @(negedge clk_in);
        tick_in = 1'b1;
        @(negedge clk_in);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        tick_in   = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        repeat (2) @(negedge clk_in);
        check_out("reset_asserted", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;

        // Idle with tick low: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check_out("idle_tick_low", 4'b1111, 7'h7F, 1'b1);
        end

        // Basic scan of 8F21 with dp on digit 2
        digits_in = 16'h8F21;
        dp_in     = 4'b0100;
        step_rise(); check_out("scan_d0", 4'b1110, 7'h79, 1'b1);
        step_rise(); check_out("scan_d1", 4'b1101, 7'h24, 1'b1);
        step_rise(); check_out("scan_d2", 4'b1011, 7'h0E, 1'b0);
        step_rise(); check_out("scan_d3", 4'b0111, 7'h00, 1'b1);
        step_rise(); check_out("wrap_d0", 4'b1110, 7'h79, 1'b1);

        // Tick held high: no advance
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check_out("tick_held_high", 4'b1110, 7'h79, 1'b1);
        end
        tick_in = 1'b0;
        @(negedge clk_in);
        check_out("falling_edge", 4'b1110, 7'h79, 1'b1);

        // Inputs change between updates: outputs hold
        digits_in = 16'h7D64;
        dp_in     = 4'b1011;
        repeat (3) @(negedge clk_in);
        check_out("hold_between_ticks", 4'b1110, 7'h79, 1'b1);
        step_rise(); check_out("new_d1", 4'b1101, 7'h02, 1'b0);
        step_rise(); check_out("new_d2", 4'b1011, 7'h21, 1'b1);
        step_rise(); check_out("new_d3", 4'b0111, 7'h78, 1'b0);
        step_rise(); check_out("new_d0", 4'b1110, 7'h19, 1'b0);

        // Tick high across reset release: only the next 0->1 advances
        digits_in = 16'h8F21;
        dp_in     = 4'b0100;
        reset     = 1'b1;
        tick_in   = 1'b1;
        repeat (2) @(negedge clk_in);
        check_out("reset_tick_high", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        check_out("release_tick_high", 4'b1111, 7'h7F, 1'b1);
        tick_in = 1'b0;
        @(negedge clk_in);
        check_out("release_tick_low", 4'b1111, 7'h7F, 1'b1);
        tick_in = 1'b1;
        @(negedge clk_in);
        check_out("first_rise_after_reset", 4'b1110, 7'h79, 1'b1);
        repeat (3) @(negedge clk_in);
        check_out("single_advance_only", 4'b1110, 7'h79, 1'b1);

        // Reset wins over a coincident rise mid-scan
        step_rise(); check_out("pre_d1", 4'b1101, 7'h24, 1'b1);
        step_rise(); check_out("pre_d2", 4'b1011, 7'h0E, 1'b0);
        tick_in = 1'b0;
        @(negedge clk_in);
        tick_in = 1'b1;
        reset   = 1'b1;
        @(negedge clk_in);
        check_out("reset_beats_rise", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;
        step_rise(); check_out("post_reset_d0", 4'b1110, 7'h79, 1'b1);

        // Leading zeros
        digits_in = 16'h0050;
        dp_in     = 4'b1000;
        step_rise(); check_out("lz_d1", 4'b1101, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        step_rise(); check_out("lz_d2_blank", 4'b1011, 7'h7F, 1'b1);
        step_rise(); check_out("lz_d3_blank", 4'b0111, 7'h7F, 1'b0);
        step_rise(); check_out("lz_d0", 4'b1110, 7'h40, 1'b1);
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        step_rise(); check_out("zero_d1_blank", 4'b1101, 7'h7F, 1'b1);
        step_rise(); check_out("zero_d2_blank", 4'b1011, 7'h7F, 1'b1);
        step_rise(); check_out("zero_d3_blank", 4'b0111, 7'h7F, 1'b1);
        step_rise(); check_out("zero_d0", 4'b1110, 7'h40, 1'b1);
`else
        step_rise(); check_out("lz_d2_shown", 4'b1011, 7'h40, 1'b1);
        step_rise(); check_out("lz_d3_shown", 4'b0111, 7'h40, 1'b0);
        step_rise(); check_out("lz_d0", 4'b1110, 7'h40, 1'b1);
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        step_rise(); check_out("zero_d1_shown", 4'b1101, 7'h40, 1'b1);
        step_rise(); check_out("zero_d2_shown", 4'b1011, 7'h40, 1'b1);
        step_rise(); check_out("zero_d3_shown", 4'b0111, 7'h40, 1'b1);
        step_rise(); check_out("zero_d0", 4'b1110, 7'h40, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter N_DIGITS, default 4, SHALL set the number of multiplexed 7-segment digits; legal range 2..8.
REQ-002 clk_in  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 tick_in  input  1  SHALL be the scan-rate square wave from the clock divider, synchronous to clk_in.
REQ-005 digits_in  input  4*N_DIGITS  SHALL hold one hex nibble per digit; nibble i = bits [4i+3:4i]; digit 0 is least significant.
REQ-006 dp_in  input  N_DIGITS  SHALL hold the decimal-point request per digit, active-high.
REQ-007 anodes_n  output  N_DIGITS  SHALL be the digit enables, active-low, one-hot-low when active.
REQ-008 segments_n  output  7  SHALL be the cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 dp_n  output  1  SHALL be the decimal-point cathode, active-low.

Function
REQ-010 The block SHALL detect a rising edge of tick_in as rise = tick_in AND NOT tick_q, where tick_q is tick_in registered on clk_in.
REQ-011 On each clock edge with rise=1, the digit index SHALL advance by 1 and wrap from N_DIGITS-1 to 0.
REQ-012 On that same edge, anodes_n, segments_n and dp_n SHALL load the values for the new index; latency = 1 clk_in cycle from tick_in first sampled high.
REQ-013 segments_n and dp_n SHALL be computed from digits_in/dp_in as sampled on the update edge; between updates all outputs SHALL hold.
REQ-014 The decode SHALL be full hex 0..F, e.g. 0 -> 7'h40, 1 -> 7'h79, 2 -> 7'h24, 8 -> 7'h00, F -> 7'h0E.
REQ-015 anodes_n SHALL drive bit [index] low and all other bits high.
REQ-016 Falling edges of tick_in and a tick_in held high SHALL cause no advance.
REQ-017 A glitch-free scan SHALL be guaranteed: anodes_n and segments_n SHALL change on the same clk_in edge, both registered.

Reset
REQ-018 When reset=1: index SHALL load N_DIGITS-1, anodes_n all 1s, segments_n 7'h7F, dp_n 1.
REQ-019 When reset=1, tick_q SHALL load tick_in, so a tick_in high across reset release produces no spurious advance.
REQ-020 reset SHALL take priority over rise on the same edge.
REQ-021 The first rise after reset SHALL select digit 0.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL blank every digit above the most significant non-zero nibble: segments_n=7'h7F, dp_n still follows dp_in; digit 0 is never blanked; all-zero input shows only digit 0 as "0".
REQ-023 Without LEADING_ZERO_BLANK_EN, every digit SHALL display its nibble, including leading zeros; no blanking logic SHALL be synthesized.

Structure
REQ-024 Package seg7_pkg SHALL hold SEG_BLANK (7'h7F), the 16-entry hex-to-segment constant table and the N_DIGITS default.
REQ-025 Sub-module seg7_decoder (combinational, 4-bit in, 7-bit active-low out) SHALL perform the hex decode and be instantiated once.

Verification
REQ-026 Reset, then hold tick_in=0 for 10 cycles -> anodes_n=4'b1111, segments_n=7'h7F, dp_n=1 throughout.
REQ-027 digits_in=16'h8F21, dp_in=4'b0100, four tick_in rising edges -> anodes_n sequence 1110,1101,1011,0111; segments_n 7'h79, 7'h24, 7'h0E, 7'h00; dp_n low only on the third step.
REQ-028 Fifth rising edge after REQ-027 -> wraps to anodes_n=4'b1110; tick_in held high 20 cycles -> no further change.
REQ-029 tick_in=1 during reset and after release, then 0, then 1 -> exactly one advance (to digit 0), on the 0->1 transition only.
REQ-030 Reset asserted on the same edge as a rise, mid-scan at digit 2 -> outputs go to reset values; the next rise selects digit 0.
REQ-031 LEADING_ZERO_BLANK_EN defined, digits_in=16'h0050 -> digit 3 blank (7'h7F), digit 2 blank, digit 1 = 7'h12, digit 0 = 7'h40; digits_in=16'h0000 -> only digit 0 shows 7'h40.
